// File: rtl/maxnet_pkg.sv
// Shared constants and loader state encoding for the MaxNet weight path.
package maxnet_pkg;
  localparam int WIDTH       = 5;
  localparam int NUM_NEURONS = 4;
  localparam int DEPTH       = NUM_NEURONS * NUM_NEURONS;
  localparam int CNT_W       = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } ld_state_e;
endpackage

// File: rtl/maxnet_weight_loader_weight_bank.sv
// DEPTH x WIDTH register bank: single-word write port plus a full-bank
// parallel load. Parallel load wins if both are requested.
module weight_bank
  import maxnet_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int D  = DEPTH,
  parameter int AW = $clog2(D)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [W-1:0]        din,
  input  logic                ld_all,
  input  logic [D-1:0][W-1:0] din_all,
  output logic [D-1:0][W-1:0] dout_all
);

  logic [D-1:0][W-1:0] mem_q;

  // Storage: clear on reset, bulk copy on ld_all, else one addressed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (ld_all) begin
      mem_q <= din_all;
    end else if (we) begin
      mem_q[addr] <= din;
    end
  end

  assign dout_all = mem_q;

endmodule

// File: rtl/maxnet_weight_loader.sv
// Serial-to-parallel MaxNet weight loader. Words stream into a shadow bank;
// a complete, correctly framed set is committed to the active bank in one
// edge once the datapath is not iterating (hold low).
module maxnet_weight_loader
  import maxnet_pkg::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int DEPTH_P = DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_P-1:0] in_data,
  input  logic               in_last,
  input  logic               hold,
  output logic [WIDTH_P-1:0] W0,
  output logic [WIDTH_P-1:0] W1,
  output logic [WIDTH_P-1:0] W2,
  output logic [WIDTH_P-1:0] W3,
  output logic [WIDTH_P-1:0] W4,
  output logic [WIDTH_P-1:0] W5,
  output logic [WIDTH_P-1:0] W6,
  output logic [WIDTH_P-1:0] W7,
  output logic [WIDTH_P-1:0] W8,
  output logic [WIDTH_P-1:0] W9,
  output logic [WIDTH_P-1:0] W10,
  output logic [WIDTH_P-1:0] W11,
  output logic [WIDTH_P-1:0] W12,
  output logic [WIDTH_P-1:0] W13,
  output logic [WIDTH_P-1:0] W14,
  output logic [WIDTH_P-1:0] W15,
  output logic               weights_valid,
  output logic               busy,
  output logic               err
);

  localparam int AW = $clog2(DEPTH_P);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_P - 1);

  ld_state_e                       state_q;
  logic [AW-1:0]                   cnt_q;
  logic                            err_q;
  logic                            wv_q;
  logic [DEPTH_P-1:0][WIDTH_P-1:0] shadow_w;
  logic [DEPTH_P-1:0][WIDTH_P-1:0] active_w;
  logic                            beat;
  logic                            commit;

  // Handshake and commit strobes are pure decodes of the registered state.
  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign beat     = in_ready && in_valid;
  assign commit   = (state_q == PEND) && !hold;

  // Loader FSM: framing check on every beat, deferred commit in PEND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wv_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (cnt_q == LAST_IDX) begin
              cnt_q <= '0;
              if (in_last) begin
                state_q <= PEND;
              end else begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            end else if (in_last) begin
              // Early in_last: abandon the set, active bank stays as it was.
              cnt_q   <= '0;
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        PEND: begin
          if (!hold) begin
            wv_q    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  weight_bank #(.W(WIDTH_P), .D(DEPTH_P)) u_shadow (
    .clk      (clk),
    .rst_n    (rst),
    .we       (beat),
    .addr     (cnt_q),
    .din      (in_data),
    .ld_all   (1'b0),
    .din_all  ('0),
    .dout_all (shadow_w)
  );

  weight_bank #(.W(WIDTH_P), .D(DEPTH_P)) u_active (
    .clk      (clk),
    .rst_n    (rst),
    .we       (1'b0),
    .addr     ('0),
    .din      ('0),
    .ld_all   (commit),
    .din_all  (shadow_w),
    .dout_all (active_w)
  );

  assign weights_valid = wv_q;
  assign err           = err_q;

  assign W0  = active_w[0];
  assign W1  = active_w[1];
  assign W2  = active_w[2];
  assign W3  = active_w[3];
  assign W4  = active_w[4];
  assign W5  = active_w[5];
  assign W6  = active_w[6];
  assign W7  = active_w[7];
  assign W8  = active_w[8];
  assign W9  = active_w[9];
  assign W10 = active_w[10];
  assign W11 = active_w[11];
  assign W12 = active_w[12];
  assign W13 = active_w[13];
  assign W14 = active_w[14];
  assign W15 = active_w[15];

endmodule

// File: tb/tb_maxnet_weight_loader.sv
// Directed bench for maxnet_weight_loader with a transaction-level model.
module tb_maxnet_weight_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       hold = 1'b0;
  logic [4:0] W0, W1, W2, W3, W4, W5, W6, W7, W8, W9, W10, W11, W12, W13, W14, W15;
  logic       weights_valid, busy, err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  maxnet_weight_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .hold(hold),
    .W0(W0), .W1(W1), .W2(W2), .W3(W3), .W4(W4), .W5(W5), .W6(W6), .W7(W7),
    .W8(W8), .W9(W9), .W10(W10), .W11(W11), .W12(W12), .W13(W13), .W14(W14), .W15(W15),
    .weights_valid(weights_valid), .busy(busy), .err(err)
  );

  logic [15:0][4:0] wbus;
  assign wbus = {W15, W14, W13, W12, W11, W10, W9, W8, W7, W6, W5, W4, W3, W2, W1, W0};

  // Model: list of received words, a loading/pending flag pair, active copy.
  logic [15:0][4:0] m_act;
  logic [4:0]       m_words[16];
  int               m_n;
  bit               m_loading, m_pending, m_wv, m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = '0; m_n = 0; m_loading = 0; m_pending = 0; m_wv = 0; m_err = 0;
    end else if (m_loading) begin
      if (in_valid) begin
        m_words[m_n] = in_data;
        m_n++;
        if ((in_last && m_n < 16) || (!in_last && m_n == 16)) begin
          m_err = 1; m_loading = 0;
        end else if (m_n == 16) begin
          m_loading = 0; m_pending = 1;
        end
      end
    end else if (m_pending) begin
      if (!hold) begin
        for (int k = 0; k < 16; k++) m_act[k] = m_words[k];
        m_wv = 1; m_pending = 0;
      end
    end else if (start) begin
      m_loading = 1; m_n = 0; m_err = 0;
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle out of reset, outputs must match the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("W bank", 80'(wbus), 80'(m_act));
      chk("weights_valid", 80'(weights_valid), 80'(m_wv));
      chk("busy", 80'(busy), 80'(m_loading || m_pending));
      chk("err", 80'(err), 80'(m_err));
      chk("in_ready", 80'(in_ready), 80'(m_loading));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic beat(input logic [4:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst W0", 80'(W0), 80'd0);
    chk("rst wv", 80'(weights_valid), 80'd0);
    chk("rst busy", 80'(busy), 80'd0);
    chk("rst in_ready", 80'(in_ready), 80'd0);
    chk("rst err", 80'(err), 80'd0);
    @(negedge clk); rst = 1'b1;
    tick();

    // Clean load 1..16, no hold
    do_start();
    for (int i = 0; i < 16; i++) beat(5'(i + 1), i == 15);
    chk("t1 busy pend", 80'(busy), 80'd1);
    tick();
    chk("t1 W0", 80'(W0), 80'h01);
    chk("t1 W15", 80'(W15), 80'h10);
    chk("t1 W6", 80'(W6), 80'h07);
    chk("t1 wv", 80'(weights_valid), 80'd1);
    chk("t1 busy", 80'(busy), 80'd0);
    chk("t1 err", 80'(err), 80'd0);

    // Load 31-i with hold high for 5 cycles after the last beat
    do_start();
    hold = 1'b1;
    for (int i = 0; i < 16; i++) beat(5'(31 - i), i == 15);
    for (int c = 0; c < 5; c++) begin
      chk("t2 busy hold", 80'(busy), 80'd1);
      chk("t2 W0 hold", 80'(W0), 80'h01);
      tick();
    end
    hold = 1'b0;
    tick();
    chk("t2 W0", 80'(W0), 80'h1f);
    chk("t2 W1", 80'(W1), 80'h1e);
    chk("t2 busy", 80'(busy), 80'd0);

    // in_last on word 10
    do_start();
    for (int i = 0; i < 10; i++) beat(5'd7, i == 9);
    chk("t3 err", 80'(err), 80'd1);
    chk("t3 busy", 80'(busy), 80'd0);
    chk("t3 W0", 80'(W0), 80'h1f);
    chk("t3 wv", 80'(weights_valid), 80'd1);

    // 16 words with no in_last
    do_start();
    chk("t4 err cleared", 80'(err), 80'd0);
    for (int i = 0; i < 16; i++) beat(5'd3, 1'b0);
    chk("t4 err", 80'(err), 80'd1);
    chk("t4 busy", 80'(busy), 80'd0);
    chk("t4 W15", 80'(W15), 80'h10);

    // Gappy load with stray start pulses during LOAD
    do_start();
    for (int i = 0; i < 16; i++) begin
      int g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        start = (j == 0) && (i % 3 == 1);
        tick();
        start = 1'b0;
      end
      start = (i == 3);
      beat(5'(i + 1), i == 15);
      start = 1'b0;
    end
    tick();
    chk("t5 W0", 80'(W0), 80'h01);
    chk("t5 W15", 80'(W15), 80'h10);
    chk("t5 err", 80'(err), 80'd0);

    // Asynchronous reset after 8 beats, then a clean load
    do_start();
    for (int i = 0; i < 8; i++) beat(5'd9, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6 W0 rst", 80'(W0), 80'd0);
    chk("t6 W15 rst", 80'(W15), 80'd0);
    chk("t6 wv rst", 80'(weights_valid), 80'd0);
    chk("t6 busy rst", 80'(busy), 80'd0);
    @(negedge clk); rst = 1'b1;
    tick();
    do_start();
    for (int i = 0; i < 16; i++) beat(5'(2 * i), i == 15);
    tick();
    chk("t6 W1", 80'(W1), 80'h02);
    chk("t6 W15", 80'(W15), 80'h1e);
    chk("t6 wv", 80'(weights_valid), 80'd1);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
